// File: rtl/WivDefines.sv
`default_nettype none
// -----------------------------------------------------------------------------
// WivDefines : shared state encoding and default sizing for wb_rr_arbiter
// Revision 1.0
// -----------------------------------------------------------------------------
package WivDefines;

  localparam int unsigned WB_N_MASTERS_DEF       = 3;
  localparam int unsigned WB_MAX_OUTSTANDING_DEF = 4;
  localparam int unsigned WB_MAX_HOLD_DEF        = 64;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANTED = 2'd1,
    ST_DRAIN   = 2'd2
  } wb_arb_state_t;

  // Index width that stays legal for a single-master build.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// -----------------------------------------------------------------------------
// rr_pick : one-hot round-robin pick, first requester strictly after i_last
// Revision 1.0
// -----------------------------------------------------------------------------
module rr_pick #(
  parameter int unsigned N     = 3,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_last,
  output logic [N-1:0]     o_gnt
);

  logic [N-1:0] w_mask;
  logic [N-1:0] w_upper;

  for (genvar j = 0; j < N; j++) begin : g_mask
    assign w_mask[j] = (IDX_W'(j) > i_last);
  end

  // Lowest set bit above the last owner wins; otherwise wrap to the lowest overall.
  assign w_upper = i_req & w_mask;
  assign o_gnt   = (|w_upper) ? (w_upper & (~w_upper + N'(1)))
                              : (i_req & (~i_req + N'(1)));

endmodule
`default_nettype wire

// File: rtl/wb_rr_arbiter.sv
`default_nettype none
// -----------------------------------------------------------------------------
// wb_rr_arbiter : round-robin Wishbone arbiter with hold-time preemption
// Revision 1.0
// -----------------------------------------------------------------------------
module wb_rr_arbiter
  import WivDefines::*;
#(
  parameter int unsigned N_MASTERS       = WB_N_MASTERS_DEF,
  parameter int unsigned MAX_OUTSTANDING = WB_MAX_OUTSTANDING_DEF,
  parameter int unsigned MAX_HOLD        = WB_MAX_HOLD_DEF
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic [N_MASTERS-1:0]      i_m_cyc,
  input  logic [N_MASTERS-1:0]      i_m_stb,
  input  logic [N_MASTERS-1:0]      i_m_we,
  input  logic [N_MASTERS-1:0]      i_m_lock,
  input  logic [64*N_MASTERS-1:0]   i_m_adr,
  input  logic [64*N_MASTERS-1:0]   i_m_dat,
  input  logic [8*N_MASTERS-1:0]    i_m_sel,
  output logic [63:0]               o_m_dat,
  output logic [N_MASTERS-1:0]      o_m_ack,
  output logic [N_MASTERS-1:0]      o_m_stall,
  output logic [N_MASTERS-1:0]      o_m_rty,
  output logic [63:0]               o_wb_adr,
  output logic [63:0]               o_wb_dat,
  output logic [7:0]                o_wb_sel,
  output logic                      o_wb_we,
  output logic                      o_wb_stb,
  output logic                      o_wb_cyc,
  input  logic [63:0]               i_wb_dat,
  input  logic                      i_wb_ack,
  input  logic                      i_wb_stall,
  output logic [N_MASTERS-1:0]      o_grant,
  output logic                      o_spurious_ack
);

  localparam int unsigned C_IDX_W  = idx_width(N_MASTERS);
  localparam int unsigned C_OUT_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned C_HOLD_W = $clog2(MAX_HOLD + 1);
  localparam logic [C_OUT_W-1:0]  C_OUT_MAX  = C_OUT_W'(MAX_OUTSTANDING);
  localparam logic [C_HOLD_W-1:0] C_HOLD_MAX = C_HOLD_W'(MAX_HOLD);
  localparam logic [C_IDX_W-1:0]  C_LAST_RST = C_IDX_W'(N_MASTERS - 1);

  wb_arb_state_t         state_q, state_d;
  logic [N_MASTERS-1:0]  grant_q, grant_d;
  logic [C_IDX_W-1:0]    last_q, last_d;
  logic [C_OUT_W-1:0]    outst_q, outst_d;
  logic [C_HOLD_W-1:0]   hold_q, hold_d;
  logic                  spur_q, spur_d;

  logic [N_MASTERS-1:0]  w_pick;
  logic [C_IDX_W-1:0]    w_owner;
  logic [63:0]           w_own_adr;
  logic [63:0]           w_own_dat;
  logic [7:0]            w_own_sel;
  logic                  w_owner_cyc;
  logic                  w_owner_stb;
  logic                  w_owner_we;
  logic                  w_owner_lock;
  logic                  w_others_cyc;
  logic                  w_active;
  logic                  w_drain;
  logic                  w_full;
  logic                  w_outst_zero;
  logic                  w_abort;
  logic                  w_release;
  logic                  w_preempt;
  logic                  w_bus_cyc;
  logic                  w_stb;
  logic                  w_accept;
  logic                  w_owner_stall;
  logic [N_MASTERS-1:0]  w_rty;

  rr_pick #(
    .N     (N_MASTERS),
    .IDX_W (C_IDX_W)
  ) u_rr_pick (
    .i_req  (i_m_cyc),
    .i_last (last_q),
    .o_gnt  (w_pick)
  );

  always_comb begin
    w_owner   = '0;
    w_own_adr = '0;
    w_own_dat = '0;
    w_own_sel = '0;
    for (int unsigned k = 0; k < N_MASTERS; k++) begin
      if (grant_q[k]) begin
        w_owner   = C_IDX_W'(k);
        w_own_adr = i_m_adr[64*k +: 64];
        w_own_dat = i_m_dat[64*k +: 64];
        w_own_sel = i_m_sel[8*k +: 8];
      end
    end
  end

  assign w_owner_cyc  = |(i_m_cyc  & grant_q);
  assign w_owner_stb  = |(i_m_stb  & grant_q);
  assign w_owner_we   = |(i_m_we   & grant_q);
  assign w_owner_lock = |(i_m_lock & grant_q);
  assign w_others_cyc = |(i_m_cyc  & ~grant_q);

  assign w_active     = (state_q != ST_IDLE);
  assign w_drain      = (state_q == ST_DRAIN);
  assign w_full       = (outst_q == C_OUT_MAX);
  assign w_outst_zero = (outst_q == '0);
  assign w_abort      = w_active && !w_owner_cyc;
  assign w_release    = w_drain && w_owner_cyc && w_outst_zero;
  assign w_preempt    = (hold_q == C_HOLD_MAX) && w_others_cyc && !w_owner_lock;

  // The release cycle already drops the bus so the rty pulse and cyc fall coincide.
  assign w_bus_cyc     = w_active && w_owner_cyc && !w_release;
  assign w_stb         = (state_q == ST_GRANTED) && w_owner_cyc && w_owner_stb && !w_full;
  assign w_accept      = w_stb && !i_wb_stall;
  assign w_owner_stall = i_wb_stall || w_full || w_drain;

  assign o_wb_cyc = w_bus_cyc;
  assign o_wb_stb = w_stb;
  assign o_wb_we  = w_bus_cyc && w_owner_we;
  assign o_wb_adr = w_bus_cyc ? w_own_adr : '0;
  assign o_wb_dat = w_bus_cyc ? w_own_dat : '0;
  assign o_wb_sel = w_bus_cyc ? w_own_sel : '0;

  assign o_m_dat   = i_wb_dat;
  assign o_m_ack   = grant_q & {N_MASTERS{i_wb_ack}};
  assign o_m_stall = ~grant_q | (grant_q & {N_MASTERS{w_owner_stall}});
  assign o_grant   = grant_q;
  assign o_spurious_ack = spur_q;

  always_comb begin
    if (!w_active) begin
      w_rty = i_m_cyc & ~w_pick;
    end else begin
      w_rty = (i_m_cyc & ~grant_q) | (grant_q & {N_MASTERS{w_release}});
    end
  end

  assign o_m_rty = i_reset ? w_rty : '0;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    outst_d = outst_q;
    hold_d  = hold_q;
    spur_d  = spur_q | (i_wb_ack & w_outst_zero);

    if (w_accept && !i_wb_ack) begin
      outst_d = outst_q + C_OUT_W'(1);
    end else if (i_wb_ack && !w_accept && !w_outst_zero) begin
      outst_d = outst_q - C_OUT_W'(1);
    end

    if ((state_q == ST_GRANTED) && (hold_q != C_HOLD_MAX)) begin
      hold_d = hold_q + C_HOLD_W'(1);
    end

    if (w_abort) begin
      grant_d = '0;
      last_d  = w_owner;
      outst_d = '0;
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (|i_m_cyc) begin
            grant_d = w_pick;
            hold_d  = '0;
            state_d = ST_GRANTED;
          end
        end
        ST_GRANTED: begin
          if (w_preempt) state_d = ST_DRAIN;
        end
        ST_DRAIN: begin
          if (w_outst_zero) begin
            grant_d = '0;
            last_d  = w_owner;
            state_d = ST_IDLE;
          end
        end
        default: begin
          grant_d = '0;
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= C_LAST_RST;
      outst_q <= '0;
      hold_q  <= '0;
      spur_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      outst_q <= outst_d;
      hold_q  <= hold_d;
      spur_q  <= spur_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_rr_arbiter.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_wb_rr_arbiter : directed self-checking bench for wb_rr_arbiter
// Revision 1.0
// -----------------------------------------------------------------------------
module tb_wb_rr_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [2:0]   m_cyc, m_stb, m_we, m_lock;
  logic [191:0] m_adr, m_dat;
  logic [23:0]  m_sel;
  logic [63:0]  m_rdat;
  logic [2:0]   m_ack, m_stall, m_rty;
  logic [63:0]  wb_adr, wb_dat;
  logic [7:0]   wb_sel;
  logic         wb_we, wb_stb, wb_cyc;
  logic [63:0]  wb_rdat;
  logic         wb_ack, wb_stall;
  logic [2:0]   grant;
  logic         spur;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  wb_rr_arbiter #(
    .N_MASTERS       (3),
    .MAX_OUTSTANDING (4),
    .MAX_HOLD        (8)
  ) dut (
    .i_clk          (clk),
    .i_reset        (rst_n),
    .i_m_cyc        (m_cyc),
    .i_m_stb        (m_stb),
    .i_m_we         (m_we),
    .i_m_lock       (m_lock),
    .i_m_adr        (m_adr),
    .i_m_dat        (m_dat),
    .i_m_sel        (m_sel),
    .o_m_dat        (m_rdat),
    .o_m_ack        (m_ack),
    .o_m_stall      (m_stall),
    .o_m_rty        (m_rty),
    .o_wb_adr       (wb_adr),
    .o_wb_dat       (wb_dat),
    .o_wb_sel       (wb_sel),
    .o_wb_we        (wb_we),
    .o_wb_stb       (wb_stb),
    .o_wb_cyc       (wb_cyc),
    .i_wb_dat       (wb_rdat),
    .i_wb_ack       (wb_ack),
    .i_wb_stall     (wb_stall),
    .o_grant        (grant),
    .o_spurious_ack (spur)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n    = 1'b0;
    m_cyc    = 3'b011;
    m_stb    = 3'b001;
    m_we     = 3'b001;
    m_lock   = 3'b000;
    m_adr    = '0;
    m_dat    = '0;
    m_sel    = '0;
    m_adr[63:0]  = 64'h1000;
    m_dat[63:0]  = 64'hA5;
    m_sel[7:0]   = 8'hFF;
    wb_rdat  = '0;
    wb_ack   = 1'b0;
    wb_stall = 1'b0;

    // Reset state, with requests already pending
    repeat (2) @(posedge clk);
    smp();
    chk("rst_grant", grant, 3'b000);
    chk("rst_wb_cyc", wb_cyc, 1'b0);
    chk("rst_wb_stb", wb_stb, 1'b0);
    chk("rst_wb_adr", wb_adr, 64'h0);
    chk("rst_stall", m_stall, 3'b111);
    chk("rst_rty", m_rty, 3'b000);
    chk("rst_ack", m_ack, 3'b000);
    chk("rst_spur", spur, 1'b0);

    // Release: masters 0 and 1 request together
    tick(); rst_n = 1'b1;
    smp();
    chk("a_grant_idle", grant, 3'b000);
    chk("a_rty_loser", m_rty, 3'b010);
    chk("a_no_stb", wb_stb, 1'b0);
    tick();
    smp();
    chk("b_grant0", grant, 3'b001);
    chk("b_stb_latency", wb_stb, 1'b1);
    chk("b_adr", wb_adr, 64'h1000);
    chk("b_we", wb_we, 1'b1);
    chk("b_sel", wb_sel, 8'hFF);
    chk("b_stall", m_stall, 3'b110);
    chk("b_rty", m_rty, 3'b010);
    tick(); m_cyc = 3'b010; m_stb = 3'b000;
    smp();
    chk("c_abort_cyc", wb_cyc, 1'b0);
    tick();
    smp();
    chk("d_idle_grant", grant, 3'b000);
    tick();
    smp();
    chk("e_grant1", grant, 3'b010);
    chk("e_wb_cyc", wb_cyc, 1'b1);
    tick(); m_cyc = 3'b000;
    tick();

    // Outstanding limit: master 0 streams, no acks
    m_cyc = 3'b001; m_stb = 3'b001; m_we = 3'b000;
    m_adr[63:0] = 64'h2000;
    smp();
    chk("f_rty", m_rty, 3'b000);
    tick();
    smp();
    chk("g_stb1", wb_stb, 1'b1);
    chk("g_stall", m_stall, 3'b110);
    tick(); tick(); tick();
    smp();
    chk("j_stb4", wb_stb, 1'b1);
    tick();
    smp();
    chk("k_stb5_held", wb_stb, 1'b0);
    chk("k_stall_full", m_stall, 3'b111);
    tick(); wb_ack = 1'b1; wb_rdat = 64'hDEAD_BEEF;
    smp();
    chk("l_stb_still_held", wb_stb, 1'b0);
    chk("l_ack", m_ack, 3'b001);
    chk("l_rdat", m_rdat, 64'hDEAD_BEEF);
    tick(); wb_ack = 1'b0;
    smp();
    chk("m_stb5_released", wb_stb, 1'b1);
    chk("m_stall", m_stall, 3'b110);

    // Simultaneous strobe and ack at outstanding 2
    tick(); m_stb = 3'b000; wb_ack = 1'b1;
    tick();
    tick(); m_stb = 3'b001;
    smp();
    chk("p_stb_with_ack", wb_stb, 1'b1);
    tick(); wb_ack = 1'b0;
    smp();
    chk("q_stb_out2", wb_stb, 1'b1);
    tick();
    smp();
    chk("r_stb_out3", wb_stb, 1'b1);
    tick(); m_stb = 3'b000; wb_ack = 1'b1;
    smp();
    chk("s_full_again", m_stall, 3'b111);
    tick(); tick(); tick();
    tick();
    smp();
    chk("w_spur_before", spur, 1'b0);
    chk("w_ack_fwd", m_ack, 3'b001);
    tick(); wb_ack = 1'b0; m_cyc = 3'b000;
    smp();
    chk("x_spur_set", spur, 1'b1);
    tick();

    // Preemption after MAX_HOLD with master 2 waiting
    m_cyc = 3'b001; m_stb = 3'b001;
    m_adr[63:0] = 64'h3000;
    smp();
    chk("y_spur_sticky", spur, 1'b1);
    tick();
    smp();
    chk("g0_grant0", grant, 3'b001);
    tick(); wb_ack = 1'b1;
    tick(); m_cyc = 3'b101;
    smp();
    chk("g2_rty2", m_rty, 3'b100);
    chk("g2_stall", m_stall, 3'b110);
    repeat (5) tick();
    tick();
    smp();
    chk("g8_still_granted", m_stall, 3'b110);
    chk("g8_stb", wb_stb, 1'b1);
    tick();
    smp();
    chk("d0_stb_blocked", wb_stb, 1'b0);
    chk("d0_stall", m_stall, 3'b111);
    chk("d0_cyc", wb_cyc, 1'b1);
    tick(); wb_ack = 1'b0;
    smp();
    chk("d1_rty_pulse", m_rty, 3'b101);
    chk("d1_cyc_drop", wb_cyc, 1'b0);
    tick(); m_cyc = 3'b100; m_stb = 3'b000;
    smp();
    chk("i0_grant", grant, 3'b000);
    chk("i0_rty", m_rty, 3'b000);
    tick();
    smp();
    chk("i1_grant2", grant, 3'b100);
    tick(); m_cyc = 3'b000;
    tick();

    // Same pattern with the owner locked
    m_cyc = 3'b001; m_stb = 3'b001; m_lock = 3'b001;
    tick();
    tick(); wb_ack = 1'b1;
    tick(); m_cyc = 3'b101;
    repeat (7) tick();
    tick();
    smp();
    chk("lk10_grant", grant, 3'b001);
    chk("lk10_stb", wb_stb, 1'b1);
    chk("lk10_rty", m_rty, 3'b100);
    chk("lk10_stall", m_stall, 3'b110);
    tick();
    tick(); m_lock = 3'b000;
    smp();
    chk("lk12_stb", wb_stb, 1'b1);
    tick(); m_lock = 3'b001;
    smp();
    chk("lkd0_stall", m_stall, 3'b111);
    chk("lkd0_stb", wb_stb, 1'b0);
    tick(); wb_ack = 1'b0;
    smp();
    chk("lkd1_rty_pulse", m_rty, 3'b101);
    chk("lkd1_cyc_drop", wb_cyc, 1'b0);
    tick(); m_cyc = 3'b000; m_stb = 3'b000; m_lock = 3'b000;
    smp();
    chk("lki0_grant", grant, 3'b000);

    // Reset with three strobes outstanding
    tick(); m_cyc = 3'b010; m_stb = 3'b010;
    m_adr[127:64] = 64'h4000;
    tick();
    smp();
    chk("r_grant1", grant, 3'b010);
    chk("r_adr1", wb_adr, 64'h4000);
    tick(); tick();
    tick(); m_stb = 3'b000;
    chk("r_cyc_before", wb_cyc, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("r_cyc_async_drop", wb_cyc, 1'b0);
    chk("r_grant_async", grant, 3'b000);
    chk("r_stall_async", m_stall, 3'b111);
    tick(); tick();
    rst_n = 1'b1; m_cyc = 3'b011; wb_ack = 1'b1;
    smp();
    chk("rr_no_ack_fwd", m_ack, 3'b000);
    chk("rr_spur_cleared", spur, 1'b0);
    tick(); wb_ack = 1'b0;
    smp();
    chk("rr_grant0_first", grant, 3'b001);
    chk("rr_outst_zero", spur, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wb_rr_arbiter.md
WB_RR_ARBITER -- requirements
Module: wb_rr_arbiter

Interface
REQ-001 SHALL have parameter N_MASTERS, default 3; number of Wishbone requesters (icache=0, dcache=1, dm=2).
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 4; maximum accepted-but-unacked strobes.
REQ-003 SHALL have parameter MAX_HOLD, default 64; grant cycles before a waiting requester may force preemption.
REQ-004 i_clk  in  1  sole clock; all state on rising edge.
REQ-005 i_reset  in  1  asynchronous, active-low reset.
REQ-006 i_m_cyc, i_m_stb, i_m_we, i_m_lock  in  N_MASTERS  per-master cycle, strobe, write and bus-lock.
REQ-007 i_m_adr, i_m_dat  in  64*N_MASTERS  per-master address and write data, packed, master k at [64k+63:64k].
REQ-008 i_m_sel  in  8*N_MASTERS  per-master byte selects.
REQ-009 o_m_dat  out  64  read data, broadcast to all masters.
REQ-010 o_m_ack, o_m_stall, o_m_rty  out  N_MASTERS  per-master ack, stall, retry.
REQ-011 o_wb_adr/o_wb_dat 64, o_wb_sel 8, o_wb_we/o_wb_stb/o_wb_cyc 1  out  downstream Wishbone master port.
REQ-012 i_wb_dat 64, i_wb_ack 1, i_wb_stall 1  in  downstream responses.
REQ-013 o_grant  out  N_MASTERS  one-hot current owner, zero when idle.
REQ-014 o_spurious_ack  out  1  sticky: ack received with zero outstanding.

Function
REQ-015 SHALL implement states IDLE, GRANTED, DRAIN.
REQ-016 IDLE: on any i_m_cyc, register grant to the first requester at or after (last_grant+1) mod N_MASTERS, and enter GRANTED next cycle; downstream port stays inactive in IDLE.
REQ-017 GRANTED: o_wb_cyc/stb/we/adr/dat/sel driven combinationally from the owner; o_wb_stb = owner stb AND NOT internal stall.
REQ-018 Owner o_m_stall = i_wb_stall OR (outstanding == MAX_OUTSTANDING) OR state==DRAIN; non-owners: stall=1, ack=0.
REQ-019 Non-owner o_m_rty = its i_m_cyc while another master owns the bus or a grant is being registered.
REQ-020 outstanding: +1 on o_wb_stb && !i_wb_stall, -1 on i_wb_ack; both same cycle -> unchanged; ack at 0 -> stays 0, sets o_spurious_ack.
REQ-021 o_m_ack[owner] = i_wb_ack; o_m_dat = i_wb_dat.
REQ-022 Owner deasserts i_m_cyc -> o_wb_cyc falls same cycle (abort), outstanding cleared, last_grant=owner, state IDLE next cycle.
REQ-023 hold counter counts owner cycles in GRANTED, saturating at MAX_HOLD; cleared on every grant.
REQ-024 GRANTED -> DRAIN when hold==MAX_HOLD AND another master has i_m_cyc AND owner i_m_lock==0.
REQ-025 DRAIN: new strobes blocked; when outstanding==0, pulse o_m_rty[owner] one cycle, drop o_wb_cyc, set last_grant=owner, enter IDLE.
REQ-026 i_m_lock high on owner SHALL suppress preemption indefinitely; lock rising while in DRAIN does not cancel DRAIN.
REQ-027 Owner cyc drop in DRAIN takes REQ-022 path.
REQ-028 Grant-to-first-strobe latency SHALL be exactly 1 cycle after IDLE sees a request.

Reset
REQ-029 Reset asserted: state IDLE, o_grant=0, outstanding=0, hold=0, last_grant=N_MASTERS-1 (master 0 wins first), o_spurious_ack=0, all o_wb_* and o_m_ack/o_m_rty 0, o_m_stall all 1.
REQ-030 Reset mid-transaction SHALL drop o_wb_cyc asynchronously; no pending ack is forwarded after release.

Structure
REQ-031 State enum wb_arb_state_t and default parameter constants SHALL live in WivDefines.
REQ-032 Round-robin priority pick SHALL be a sub-module rr_pick (request vector, last grant -> one-hot); remainder flat.

Verification
REQ-033 Reset release, masters 0 and 1 raise cyc same cycle -> o_grant=001 one cycle later; after 0 drops cyc, o_grant=010.
REQ-034 Owner issues 5 strobes, no acks, i_wb_stall=0 -> 4 reach o_wb_stb, 5th held by o_m_stall until first ack.
REQ-035 MAX_HOLD=8, master 0 streams, master 2 requests at cycle 2 -> DRAIN at hold 8, rty[0] pulse after last ack, o_grant=100 next-but-one cycle.
REQ-036 Same as REQ-035 with i_m_lock[0]=1 -> no preemption, master 2 sees rty=1, stall=1 throughout.
REQ-037 Stb+ack same cycle at outstanding 2 -> stays 2; ack at outstanding 0 -> o_spurious_ack=1 until reset.
REQ-038 Reset asserted with outstanding=3 -> o_wb_cyc=0 immediately; after release outstanding=0, master 0 granted first.
